// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and frame byte selection for lcd_row_writer.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_FRAME
  } lcd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HIGH,
    TX_WAIT
  } tx_phase_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE0    = 8'h80;
  localparam logic [7:0] LCD_LINE1    = 8'hC0;

  localparam int LCD_FRAME_BYTES = 34;
  localparam int LCD_INIT_BYTES  = 4;

  function automatic logic [7:0] init_cmd(input logic [5:0] idx);
    case (idx)
      6'd0:    return LCD_FUNC_SET;
      6'd1:    return LCD_DISP_ON;
      6'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Returns {rs, data} for frame byte idx; shadow is {top_row, bottom_row}.
  function automatic logic [8:0] frame_byte(input logic [255:0] shadow, input logic [5:0] idx);
    logic [255:0] sh;
    int k;
    if (idx == 6'd0) return {1'b0, LCD_LINE0};
    if (idx == 6'd17) return {1'b0, LCD_LINE1};
    k  = (idx < 6'd17) ? int'(idx) - 1 : int'(idx) - 2;
    sh = shadow << (8 * k);
    return {1'b1, sh[255:248]};
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 write strobe: setup with E low, E high pulse, then post-E wait.
// ready is high when idle or in the last wait cycle, so bytes can go back-to-back.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 12,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       ready,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_db
);

  localparam int MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

  tx_phase_t        phase, phase_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             long_q, long_d;

  assign ready  = (phase == TX_IDLE) || ((phase == TX_WAIT) && (cnt == '0));
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase  <= TX_IDLE;
      cnt    <= '0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      db_q   <= 8'h00;
      long_q <= 1'b0;
    end else begin
      phase  <= phase_d;
      cnt    <= cnt_d;
      e_q    <= e_d;
      rs_q   <= rs_d;
      db_q   <= db_d;
      long_q <= long_d;
    end
  end

  // RS/DB only change when a new byte is taken, so they hold through the wait.
  always_comb begin
    phase_d = phase;
    cnt_d   = cnt;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    long_d  = long_q;
    if (go && ready) begin
      phase_d = TX_SETUP;
      cnt_d   = SETUP_LD;
      e_d     = 1'b0;
      rs_d    = rs;
      db_d    = data;
      long_d  = long_wait;
    end else begin
      case (phase)
        TX_SETUP: begin
          if (cnt == '0) begin
            phase_d = TX_HIGH;
            cnt_d   = HIGH_LD;
            e_d     = 1'b1;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        TX_HIGH: begin
          if (cnt == '0) begin
            phase_d = TX_WAIT;
            cnt_d   = long_q ? CLR_LD : CMD_LD;
            e_d     = 1'b0;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        TX_WAIT: begin
          if (cnt == '0) phase_d = TX_IDLE;
          else           cnt_d   = cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_row_writer.sv
// Writes two 16-char rows to an HD44780 16x2 LCD after a one-time power-up/init.
// Optional LCD_AUTO_REFRESH_EN: repaint continuously, re-sampling rows each frame.
//
//   state    | meaning
//   PWRUP    | power-up delay, LCD pins idle at 0
//   INIT     | sending function set, display on, entry mode, clear
//   IDLE     | waiting for start (busy low)
//   FRAME    | sending line0 addr, 16 top chars, line1 addr, 16 bottom chars
module lcd_row_writer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 2000000,
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 12,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] u_row,
  input  logic [127:0] d_row,
  output logic         busy,
  output logic         done,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_db
);

  localparam int MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (PWRUP_CYC > MAX_C) ? PWRUP_CYC : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);

  lcd_state_t       state, state_d;
  logic [CNT_W-1:0] pwr_cnt, pwr_cnt_d;
  logic [5:0]       idx, idx_d;
  logic [255:0]     shadow, shadow_d;
  logic             done_q, done_d;
  logic             accept;
  logic             go, tx_rs, tx_long, tx_ready;
  logic [7:0]       tx_data;

`ifdef LCD_AUTO_REFRESH_EN
  assign accept = (state == ST_IDLE);
  assign busy   = 1'b1;
`else
  assign accept = (state == ST_IDLE) && start;
  assign busy   = (state != ST_IDLE);
`endif

  assign done   = done_q;
  assign lcd_rw = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_PWRUP;
      pwr_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pwr_cnt <= pwr_cnt_d;
      idx     <= idx_d;
      shadow  <= shadow_d;
      done_q  <= done_d;
    end
  end

  // idx counts bytes already handed to the strobe; the end test runs once the last wait expires.
  always_comb begin
    state_d   = state;
    pwr_cnt_d = pwr_cnt;
    idx_d     = idx;
    shadow_d  = shadow;
    done_d    = 1'b0;
    go        = 1'b0;
    tx_rs     = 1'b0;
    tx_data   = 8'h00;
    tx_long   = 1'b0;
    case (state)
      ST_PWRUP: begin
        if (pwr_cnt == PWRUP_LAST) state_d   = ST_INIT;
        else                       pwr_cnt_d = pwr_cnt + CNT_W'(1);
      end
      ST_INIT: begin
        if (tx_ready) begin
          if (idx == 6'(LCD_INIT_BYTES)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            go      = 1'b1;
            tx_data = init_cmd(idx);
            tx_long = (init_cmd(idx) == LCD_CLEAR);
            idx_d   = idx + 6'd1;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          shadow_d = {u_row, d_row};
          go       = 1'b1;
          tx_data  = LCD_LINE0;
          idx_d    = 6'd1;
          state_d  = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (tx_ready) begin
          if (idx == 6'(LCD_FRAME_BYTES)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            go               = 1'b1;
            {tx_rs, tx_data} = frame_byte(shadow, idx);
            idx_d            = idx + 6'd1;
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  lcd_byte_tx #(
    .SETUP_CYC    (SETUP_CYC),
    .E_HIGH_CYC   (E_HIGH_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .rs        (tx_rs),
    .data      (tx_data),
    .long_wait (tx_long),
    .ready     (tx_ready),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_db    (lcd_db)
  );

endmodule

// File: tb/tb_lcd_row_writer.sv
// Self-checking bench for lcd_row_writer with short timing parameters.
// Build with LCD_AUTO_REFRESH_EN defined to exercise the auto-refresh sequence.
module tb_lcd_row_writer;

  localparam int PWR = 20;
  localparam int S   = 2;
  localparam int H   = 3;
  localparam int CW  = 5;
  localparam int CL  = 30;
  localparam int P   = S + H + CW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] u_row, d_row;
  logic         busy, done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]   lcd_db;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_cnt   = 0;

  typedef struct {
    logic [8:0] v;
    int         c;
  } cap_t;
  cap_t cap[$];

  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  lcd_row_writer #(
    .PWRUP_CYC    (PWR),
    .SETUP_CYC    (S),
    .E_HIGH_CYC   (H),
    .CMD_WAIT_CYC (CW),
    .CLR_WAIT_CYC (CL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .u_row  (u_row),
    .d_row  (d_row),
    .busy   (busy),
    .done   (done),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_db (lcd_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference frame: line0 addr, top chars left to right, line1 addr, bottom chars.
  function automatic logic [8:0] exp_byte(input logic [127:0] u, input logic [127:0] d, input int j);
    logic [127:0] row;
    int k;
    if (j == 0)  return 9'h080;
    if (j == 17) return 9'h0C0;
    if (j < 17) begin row = u; k = j - 1;  end
    else        begin row = d; k = j - 18; end
    row = row >> (8 * (15 - k));
    return {1'b1, row[7:0]};
  endfunction

  // Bus monitor: setup before E rise, stable while high, E width, capture on fall.
  logic       prev_e = 1'b0;
  logic [8:0] hist1, hist2, rise_val;
  int         rise_cyc;
  always @(negedge clk) begin
    chk("rw_low", lcd_rw, 1'b0);
    if (lcd_e && !prev_e) begin
      chk("setup_hold_1", hist1, {lcd_rs, lcd_db});
      chk("setup_hold_2", hist2, {lcd_rs, lcd_db});
      rise_cyc = cyc;
      rise_val = {lcd_rs, lcd_db};
    end
    if (lcd_e && prev_e) chk("e_high_stable", {lcd_rs, lcd_db}, rise_val);
    if (!lcd_e && prev_e) begin
      chk("e_width", cyc - rise_cyc, H);
      cap.push_back('{v: {lcd_rs, lcd_db}, c: cyc});
    end
    if (done === 1'b1) done_cnt++;
    hist2  = hist1;
    hist1  = {lcd_rs, lcd_db};
    prev_e = lcd_e;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_e"}, lcd_e, 1'b0);
    chk({tag, "_rs"}, lcd_rs, 1'b0);
    chk({tag, "_rw"}, lcd_rw, 1'b0);
    chk({tag, "_db"}, lcd_db, 8'h00);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic check_init(input int r, input logic busy_after);
    int i;
    int target;
    i = 0;
    while (cap.size() < 4 && i < PWR + 4 * P + CL + 50) begin
      @(negedge clk);
      i++;
    end
    chk("init_count", cap.size(), 4);
    if (cap.size() >= 4) begin
      for (int j = 0; j < 4; j++) chk($sformatf("init_byte%0d", j), cap[j].v, {1'b0, init_cmds[j]});
      chk("init_pwrup_idle", (cap[0].c >= r + PWR + S + H), 1'b1);
      for (int j = 1; j < 4; j++) chk($sformatf("init_spacing%0d", j), cap[j].c - cap[j-1].c, P);
      target = cap[3].c + CL;
      while (cyc < target - 1) @(negedge clk);
      chk("init_busy_before_end", busy, 1'b1);
      @(negedge clk);
      chk("init_busy_after_end", busy, busy_after);
    end
    cap.delete();
  endtask

  task automatic check_frame(input int a, input logic [127:0] u, input logic [127:0] d,
                             input logic exp_busy);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 34 * P + 60) begin
      @(negedge clk);
      i++;
    end
    chk("frame_done_seen", done, 1'b1);
    if (a >= 0) chk("frame_done_cycle", cyc, a + 34 * P);
    chk("busy_at_done", busy, exp_busy);
    chk("frame_byte_count", cap.size(), 34);
    for (int j = 0; j < 34 && j < cap.size(); j++) begin
      chk($sformatf("frame_byte%0d", j), cap[j].v, exp_byte(u, d, j));
      if (a >= 0) chk($sformatf("frame_byte%0d_cycle", j), cap[j].c, a + j * P + S + H);
    end
    cap.delete();
  endtask

  initial begin
    logic [127:0] u1, d1, u2, d2, u3, d3;
    int a, r, dprev;
    u1 = "12:34 Time's up!";
    d1 = "Time 05:00      ";
    rst_n = 1'b0;
    start = 1'b0;
    u_row = u1;
    d_row = d1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    r = cyc + 1;

`ifdef LCD_AUTO_REFRESH_EN
    check_init(r, 1'b1);
    check_frame(-1, u1, d1, 1'b1);
    dprev = cyc;
    repeat (100) @(negedge clk);
    d2 = rand128();
    d_row = d2;
    check_frame(dprev + 1, u1, d1, 1'b1);
    dprev = cyc;
    check_frame(dprev + 1, u1, d2, 1'b1);
    @(negedge clk);
    chk("auto_done_pulse_width", done, 1'b0);
    chk("auto_done_count", done_cnt, 3);
`else
    check_init(r, 1'b0);

    // Directed frame with start held high for the whole frame; inputs scrambled mid-frame.
    start = 1'b1;
    a = cyc + 1;
    cap.delete();
    @(negedge clk);
    chk("accept_busy", busy, 1'b1);
    chk("accept_first_byte", {lcd_rs, lcd_db}, 9'h080);
    chk("accept_e_low", lcd_e, 1'b0);
    repeat (100) @(negedge clk);
    u_row = rand128();
    d_row = rand128();
    check_frame(a, u1, d1, 1'b0);

    // start still high in the done cycle: second frame starts straight away.
    u2 = rand128();
    d2 = rand128();
    u_row = u2;
    d_row = d2;
    a = cyc + 1;
    @(negedge clk);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done_low", done, 1'b0);
    chk("b2b_first_byte", {lcd_rs, lcd_db}, 9'h080);
    start = 1'b0;
    check_frame(a, u2, d2, 1'b0);
    repeat (20) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_no_queued_bytes", cap.size(), 0);
    chk("done_count_2", done_cnt, 2);

    // Frame aborted by reset at byte 10.
    u3 = rand128();
    d3 = rand128();
    u_row = u3;
    d_row = d3;
    start = 1'b1;
    a = cyc + 1;
    cap.delete();
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 10 * P + 1) @(negedge clk);
    chk("abort_byte10_on_bus", {lcd_rs, lcd_db}, exp_byte(u3, d3, 10));
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("abort");
    cap.delete();
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc + 1;
    check_init(r, 1'b0);
    chk("no_done_after_abort", done_cnt, 2);

    // Random frame after re-init, non-printable codes included.
    u2 = rand128();
    d2 = rand128();
    u_row = u2;
    d_row = d2;
    start = 1'b1;
    a = cyc + 1;
    cap.delete();
    @(negedge clk);
    start = 1'b0;
    check_frame(a, u2, d2, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", done, 1'b0);
    chk("done_count_3", done_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
